// File: rtl/opt_crypt_sequencer.sv
// opt_crypt_sequencer
//   Sequences the byte-wide encrypt/decrypt core. Accepts commands one byte at a time:
//   KEY, MODE, DATA and CLEAR. For each DATA byte it starts one core operation,
//   waits for the core result and presents that result on a valid/ready output.
//
//   Optional build macro: SEQ_TIMEOUT_EN
//     When this macro is defined, a core_done watchdog limits the WAIT state to
//     TIMEOUT_CYC cycles. If the watchdog expires, err[1] is set.
//     When the macro is not defined, WAIT has no time limit and err[1] is always 0.
//
//   Handshakes:
//     - A command transfers on in_valid && in_ready.
//     - A result transfers on out_valid && out_ready.
//     - out_valid and out_data stay stable until the result transfers.
//     - in_ready is high only in IDLE. It is held low while reset is asserted.
//     - core_start is a one-cycle pulse, issued in the ISSUE state.
//     - core_done is sampled only in the WAIT state.
//
//   fsm_state exposes the FSM state for debug and monitoring:
//     0 IDLE, 1 ISSUE, 2 WAIT, 3 OUT.
module opt_crypt_sequencer #(
  parameter int KEY_BYTES   = 4,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_cmd,
  input  logic [7:0] in_data,
  output logic       core_start,
  output logic [7:0] core_din,
  output logic [7:0] core_key,
  output logic       core_mode,
  input  logic       core_done,
  input  logic [7:0] core_dout,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       key_loaded,
  output logic       busy,
  output logic [1:0] err,
  output logic [1:0] fsm_state
);

  localparam int PW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(KEY_BYTES - 1);
  localparam logic [3:0] TLIMIT = 4'(TIMEOUT_CYC - 1);

  localparam logic [1:0] CMD_DATA  = 2'b00;
  localparam logic [1:0] CMD_KEY   = 2'b01;
  localparam logic [1:0] CMD_MODE  = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [7:0]    key_q [KEY_BYTES];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] kidx;
  logic          mode_q;
  logic [1:0]    err_q;
  logic [3:0]    tcnt;

  logic cmd_fire;
  logic data_go;
  logic data_nokey;
  logic done_ok;
  logic timeout_en;
  logic timeout_hit;

`ifdef SEQ_TIMEOUT_EN
  assign timeout_en = 1'b1;
`else
  assign timeout_en = 1'b0;
`endif

  assign in_ready    = (state_q == S_IDLE) && rst_n;
  assign cmd_fire    = in_valid && in_ready;
  assign data_go     = cmd_fire && (in_cmd == CMD_DATA) && key_loaded;
  assign data_nokey  = cmd_fire && (in_cmd == CMD_DATA) && !key_loaded;
  assign done_ok     = (state_q == S_WAIT) && core_done;
  // A core_done that arrives in the limit cycle takes priority over the timeout.
  assign timeout_hit = timeout_en && (state_q == S_WAIT) && !core_done && (tcnt == TLIMIT);

  assign core_start = (state_q == S_ISSUE);
  assign core_mode  = mode_q;
  assign busy       = (state_q != S_IDLE);
  assign err        = err_q;
  assign fsm_state  = state_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (data_go) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (core_done)        state_d = S_OUT;
        else if (timeout_hit) state_d = S_IDLE;
      end
      S_OUT:   if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Key storage and key write pointer. KEY commands write here; CLEAR wipes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < KEY_BYTES; i++) key_q[i] <= 8'h00;
      wr_ptr     <= '0;
      key_loaded <= 1'b0;
    end else if (cmd_fire && in_cmd == CMD_CLEAR) begin
      for (int i = 0; i < KEY_BYTES; i++) key_q[i] <= 8'h00;
      wr_ptr     <= '0;
      key_loaded <= 1'b0;
    end else if (cmd_fire && in_cmd == CMD_KEY) begin
      key_q[wr_ptr] <= in_data;
      if (wr_ptr == LAST_IDX) begin
        wr_ptr     <= '0;
        key_loaded <= 1'b1;
      end else begin
        wr_ptr <= wr_ptr + PW'(1);
      end
    end
  end

  // Rotating key index. It advances only after a completed core operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kidx <= '0;
    end else if (cmd_fire && (in_cmd == CMD_CLEAR || in_cmd == CMD_MODE)) begin
      kidx <= '0;
    end else if (done_ok) begin
      kidx <= (kidx == LAST_IDX) ? '0 : kidx + PW'(1);
    end
  end

  // Mode register. CLEAR does not change it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              mode_q <= 1'b0;
    else if (cmd_fire && in_cmd == CMD_MODE) mode_q <= in_data[0];
  end

  // Core operands, latched when DATA is accepted.
  // They stay stable through ISSUE and WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_din <= 8'h00;
      core_key <= 8'h00;
    end else if (data_go) begin
      core_din <= in_data;
      core_key <= key_q[kidx];
    end
  end

  // Result holding register for the valid/ready output port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= 8'h00;
    end else if (done_ok) begin
      out_valid <= 1'b1;
      out_data  <= core_dout;
    end else if (state_q == S_OUT && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky error flags. Only CLEAR or reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 2'b00;
    end else if (cmd_fire && in_cmd == CMD_CLEAR) begin
      err_q <= 2'b00;
    end else begin
      if (data_nokey)  err_q[0] <= 1'b1;
      if (timeout_hit) err_q[1] <= 1'b1;
    end
  end

  // Watchdog counter. It restarts in ISSUE, so every WAIT begins at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   tcnt <= 4'd0;
    else if (state_q == S_ISSUE)  tcnt <= 4'd0;
    else if (state_q == S_WAIT)   tcnt <= tcnt + 4'd1;
  end

endmodule

// File: tb/tb_opt_crypt_sequencer.sv
// Directed testbench for opt_crypt_sequencer.
// The bench drives inputs and samples outputs on the falling clock edge.
// The core is modelled as din ^ key.
module tb_opt_crypt_sequencer;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_cmd;
  logic [7:0] in_data;
  logic       core_start;
  logic [7:0] core_din;
  logic [7:0] core_key;
  logic       core_mode;
  logic       core_done;
  logic [7:0] core_dout;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       key_loaded;
  logic       busy;
  logic [1:0] err;
  logic [1:0] fsm_state;

  int checks;
  int failures;

  opt_crypt_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_cmd     (in_cmd),
    .in_data    (in_data),
    .core_start (core_start),
    .core_din   (core_din),
    .core_key   (core_key),
    .core_mode  (core_mode),
    .core_done  (core_done),
    .core_dout  (core_dout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .key_loaded (key_loaded),
    .busy       (busy),
    .err        (err),
    .fsm_state  (fsm_state)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  // Present one command and return on the negedge after it is accepted.
  task automatic send_cmd(input logic [1:0] cmd, input logic [7:0] data);
    int n;
    in_valid = 1'b1;
    in_cmd   = cmd;
    in_data  = data;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL cmd_accept_timeout got in_ready=%0b want 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Load the four key bytes.
  task automatic load_key();
    send_cmd(2'b01, 8'h11);
    send_cmd(2'b01, 8'h22);
    send_cmd(2'b01, 8'h33);
    send_cmd(2'b01, 8'h44);
  endtask

  // Run one DATA byte end to end.
  // Return what the core port showed in ISSUE and the result that was delivered.
  task automatic run_byte(input logic [7:0] din, input logic [7:0] res,
                          output logic s_start, output logic [7:0] s_din,
                          output logic [7:0] s_key, output logic s_mode,
                          output logic s_valid, output logic [7:0] s_out);
    send_cmd(2'b00, din);
    s_start = core_start;
    s_din   = core_din;
    s_key   = core_key;
    s_mode  = core_mode;
    @(negedge clk);
    core_done = 1'b1;
    core_dout = res;
    @(negedge clk);
    core_done = 1'b0;
    s_valid   = out_valid;
    s_out     = out_data;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // Scenario tasks
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, core_start, core_din, core_key, core_mode, out_valid, out_data,
         key_loaded, busy, err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got rdy=%0b st=%0b din=%h key=%h md=%0b ov=%0b od=%h kl=%0b bz=%0b err=%b want all 0",
               in_ready, core_start, core_din, core_key, core_mode, out_valid, out_data,
               key_loaded, busy, err);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || fsm_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_release got in_ready=%0b state=%0d want 1/0", in_ready, fsm_state);
    end
  endtask

  task automatic test_no_key();
    logic saw_start;
    logic saw_valid;
    send_cmd(2'b00, 8'hA5);
    saw_start = core_start;
    saw_valid = out_valid;
    checks++;
    if (err !== 2'b01) begin
      failures++;
      $display("FAIL nokey_err got %b want 01", err);
    end
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL nokey_ready got in_ready=%0b busy=%0b want 1/0", in_ready, busy);
    end
    repeat (3) begin
      @(negedge clk);
      saw_start = saw_start | core_start;
      saw_valid = saw_valid | out_valid;
    end
    checks++;
    if (saw_start !== 1'b0 || saw_valid !== 1'b0) begin
      failures++;
      $display("FAIL nokey_no_op got start=%0b valid=%0b want 0/0", saw_start, saw_valid);
    end
  endtask

  task automatic test_key_load();
    logic st;
    logic md;
    logic vl;
    logic [7:0] d;
    logic [7:0] k;
    logic [7:0] o;
    send_cmd(2'b01, 8'h11);
    send_cmd(2'b01, 8'h22);
    send_cmd(2'b01, 8'h33);
    checks++;
    if (key_loaded !== 1'b0) begin
      failures++;
      $display("FAIL key_loaded_early got %0b want 0", key_loaded);
    end
    send_cmd(2'b01, 8'h44);
    checks++;
    if (key_loaded !== 1'b1) begin
      failures++;
      $display("FAIL key_loaded got %0b want 1", key_loaded);
    end
    run_byte(8'hFF, 8'hEE, st, d, k, md, vl, o);
    checks++;
    if (st !== 1'b1 || d !== 8'hFF || k !== 8'h11 || md !== 1'b0) begin
      failures++;
      $display("FAIL first_issue got start=%0b din=%h key=%h mode=%0b want 1/ff/11/0", st, d, k, md);
    end
    checks++;
    if (vl !== 1'b1 || o !== 8'hEE) begin
      failures++;
      $display("FAIL first_result got valid=%0b data=%h want 1/ee", vl, o);
    end
  endtask

  task automatic test_key_rotation();
    logic [7:0] kexp [5];
    logic [7:0] dins [5];
    logic st;
    logic md;
    logic vl;
    logic [7:0] d;
    logic [7:0] k;
    logic [7:0] o;
    kexp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    dins = '{8'h01, 8'h80, 8'h3C, 8'hC3, 8'h7E};
    send_cmd(2'b10, 8'h00);
    for (int i = 0; i < 5; i++) begin
      run_byte(dins[i], dins[i] ^ kexp[i], st, d, k, md, vl, o);
      checks++;
      if (st !== 1'b1 || d !== dins[i] || k !== kexp[i]) begin
        failures++;
        $display("FAIL rotate_issue[%0d] got start=%0b din=%h key=%h want 1/%h/%h", i, st, d, k, dins[i], kexp[i]);
      end
      checks++;
      if (vl !== 1'b1 || o !== (dins[i] ^ kexp[i])) begin
        failures++;
        $display("FAIL rotate_result[%0d] got valid=%0b data=%h want 1/%h", i, vl, o, dins[i] ^ kexp[i]);
      end
    end
    send_cmd(2'b10, 8'h01);
    run_byte(8'h5A, 8'h4B, st, d, k, md, vl, o);
    checks++;
    if (k !== 8'h11 || md !== 1'b1 || o !== 8'h4B) begin
      failures++;
      $display("FAIL mode1_issue got key=%h mode=%0b out=%h want 11/1/4b", k, md, o);
    end
  endtask

  task automatic test_backpressure();
    logic stable;
    // A core_done pulse while the FSM is idle must be ignored.
    core_done = 1'b1;
    core_dout = 8'h99;
    @(negedge clk);
    core_done = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL stray_done got valid=%0b busy=%0b want 0/0", out_valid, busy);
    end
    send_cmd(2'b00, 8'h0F);
    @(negedge clk);
    checks++;
    if (fsm_state !== 2'd2 || core_start !== 1'b0 || core_din !== 8'h0F) begin
      failures++;
      $display("FAIL wait_stable got state=%0d start=%0b din=%h want 2/0/0f", fsm_state, core_start, core_din);
    end
    core_done = 1'b1;
    core_dout = 8'h5A;
    @(negedge clk);
    core_done = 1'b0;
    core_dout = 8'h00;
    stable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (out_valid !== 1'b1 || out_data !== 8'h5A || in_ready !== 1'b0) stable = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (stable !== 1'b1) begin
      failures++;
      $display("FAIL hold_result got stable=%0b (valid=%0b data=%h) want 1", stable, out_valid, out_data);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL release_result got valid=%0b in_ready=%0b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_clear();
    send_cmd(2'b11, 8'h00);
    checks++;
    if (key_loaded !== 1'b0 || err !== 2'b00 || core_mode !== 1'b1) begin
      failures++;
      $display("FAIL clear got kl=%0b err=%b mode=%0b want 0/00/1", key_loaded, err, core_mode);
    end
    send_cmd(2'b00, 8'h12);
    checks++;
    if (err !== 2'b01 || core_start !== 1'b0) begin
      failures++;
      $display("FAIL clear_nokey got err=%b start=%0b want 01/0", err, core_start);
    end
  endtask

  task automatic test_reset_in_wait();
    load_key();
    send_cmd(2'b00, 8'h33);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, core_start, core_din, core_key, core_mode, out_valid, out_data,
         key_loaded, busy, err} !== '0) begin
      failures++;
      $display("FAIL abort_outputs got st=%0b din=%h key=%h md=%0b ov=%0b kl=%0b bz=%0b err=%b want all 0",
               core_start, core_din, core_key, core_mode, out_valid, key_loaded, busy, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    core_done = 1'b1;
    core_dout = 8'hAB;
    @(negedge clk);
    core_done = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || key_loaded !== 1'b0) begin
      failures++;
      $display("FAIL late_done got valid=%0b busy=%0b kl=%0b want 0/0/0", out_valid, busy, key_loaded);
    end
  endtask

`ifdef SEQ_TIMEOUT_EN
  task automatic test_timeout();
    logic st;
    logic md;
    logic vl;
    logic [7:0] d;
    logic [7:0] k;
    logic [7:0] o;
    int waits;
    int n;
    logic saw_valid;
    load_key();
    send_cmd(2'b10, 8'h00);
    run_byte(8'h10, 8'h01, st, d, k, md, vl, o);
    send_cmd(2'b00, 8'h20);
    waits = 0;
    n = 0;
    saw_valid = 1'b0;
    while (busy && n < 40) begin
      if (fsm_state == 2'd2) waits++;
      saw_valid = saw_valid | out_valid;
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0 || waits != 15) begin
      failures++;
      $display("FAIL timeout_len got busy=%0b waits=%0d want 0/15", busy, waits);
    end
    checks++;
    if (err !== 2'b10 || saw_valid !== 1'b0) begin
      failures++;
      $display("FAIL timeout_err got err=%b valid=%0b want 10/0", err, saw_valid);
    end
    run_byte(8'h30, 8'h12, st, d, k, md, vl, o);
    checks++;
    if (k !== 8'h22 || o !== 8'h12) begin
      failures++;
      $display("FAIL timeout_kidx got key=%h out=%h want 22/12", k, o);
    end
  endtask
`endif

  // Test sequence and final report
  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_cmd    = 2'b00;
    in_data   = 8'h00;
    core_done = 1'b0;
    core_dout = 8'h00;
    out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_no_key();
    test_key_load();
    test_key_rotation();
    test_backpressure();
    test_clear();
    test_reset_in_wait();
`ifdef SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
